if_stage: RTL
=============

# if_stage

Instruction-fetch stage with integrated IF/ID pipeline register. It sits directly upstream of the decode stage. It owns the PC and runs a one-outstanding-request handshake to instruction memory. It delivers `instr`/`pc_ID`/`valid_ID` to decode, honouring hazard stalls and branch flushes, and inserts a NOP bubble whenever no valid instruction is available.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch byte address. Must stay stable while `imem_req && !imem_ready`.
- `imem_rdata` in 32: instruction word, valid when `imem_ready` is high.
- `imem_ready` in 1: response for the current request, sampled only when `imem_req` is high.
- `stall` in 1: hold the IF/ID register (from hazard unit).
- `flush` in 1: branch taken; redirect fetch and squash the IF/ID register.
- `branch_target` in 32: redirect address; bits [1:0] are forced to 0.
- `instr` out 32: IF/ID instruction, drives decode.
- `pc_ID` out 32: PC of `instr`.
- `valid_ID` out 1: `instr` is a real fetched instruction (0 = bubble).

## Operation
- Registers:
  - `pc`: next fetch address.
  - `drain_addr`: address held during a drain.
  - `skid`/`skid_pc`: one-entry buffer.
  - IF/ID register: `instr`, `pc_ID`, `valid_ID`.
  - `state` ∈ {IDLE, FETCH, HOLD, DRAIN}.
- Outputs:
  - `imem_req` = 1 in FETCH and DRAIN, 0 in IDLE and HOLD.
  - `imem_addr` = `drain_addr` in DRAIN, `pc` otherwise.
- "Bubble" means IF/ID ← {`NOP`, `pc_ID` unchanged, 0}.
- IDLE: always → FETCH on the next edge.
- FETCH, rules in priority order:
  - `flush`, `ready`=0: `drain_addr`←`pc`; `pc`←target; bubble; → DRAIN.
  - `flush`, `ready`=1: response discarded; `pc`←target; bubble; stay.
  - `ready`=1, `stall`=0: IF/ID ← {`imem_rdata`, `pc`, 1}; `pc`←`pc`+4.
  - `ready`=1, `stall`=1: `skid`←{`imem_rdata`, `pc`}; `pc`←`pc`+4; IF/ID holds; → HOLD.
  - `ready`=0, `stall`=1: IF/ID holds; request continues.
  - `ready`=0, `stall`=0: bubble.
- HOLD:
  - `flush`: `pc`←target; `skid` dropped; bubble; → FETCH.
  - `stall`=0: IF/ID ← {`skid`, `skid_pc`, 1}; → FETCH.
  - `stall`=1: hold.
- DRAIN:
  - `flush`: `pc`←new target; stay in DRAIN.
  - `ready`=1: response discarded; → FETCH.
  - IF/ID: holds if `stall`, else bubble.
- `flush` overrides `stall` in every state.
- `pc`+4 wraps modulo 2^32.

## Timing
- Reset values (asynchronous):
  - `state`=IDLE, `pc`=`RESET_PC`.
  - `instr`=`NOP`, `pc_ID`=0, `valid_ID`=0.
  - `imem_req`=0, `drain_addr`=0, `skid`=0.
- First request is asserted in the second cycle after `rst` deasserts (one IDLE cycle).
- Latency: a word accepted with `imem_ready` at edge N appears on `instr` after edge N.
- Throughput: 1 instr/cycle with zero-wait memory.
- Redirect: with zero-wait memory, `imem_addr`=target in the cycle after `flush`; the target instruction reaches `instr` one cycle later.
- No instruction is lost or duplicated across any stall/flush sequence.
- Wrong-path data is never marked valid.
- `rst` asserted mid-request: everything returns to reset values immediately. Any pending memory response is ignored, because `imem_req`=0 and the FSM restarts from IDLE.

## Test plan
- Reset, zero-wait memory (`imem_ready`=1, rdata = addr ^ 32'hA5A5_0000), `RESET_PC`=0x100: `imem_req` rises 2 cycles after release. `instr` shows words for 0x100, 0x104, 0x108 on consecutive cycles with `valid_ID`=1.
- `stall` held 3 cycles mid-stream: IF/ID frozen, state HOLD, `imem_req`=0. On release, the skid word (next PC) appears, then the sequence continues with no gap or duplicate.
- `flush` with target 0x200 while the 0x10C request is being accepted: `instr`=`NOP`/`valid_ID`=0 for one cycle, next request is at 0x200, and 0x10C never becomes valid.
- Memory with 3-cycle wait, `flush` (target 0x400) in the first wait cycle: `imem_addr` stays at the old address until `ready` (DRAIN). The response is discarded, then the fetch goes to 0x400.
- `flush` and `stall` together in HOLD: skid dropped, bubble, fetch resumes at target.
- `rst` pulsed during a waited request: outputs go to reset values asynchronously. Fetch restarts at `RESET_PC` and the late `imem_ready` is ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register; owns the PC and one outstanding imem request.
// Latency: a word accepted with imem_ready at edge N is on instr after edge N (1 instr/cycle at zero wait).
// Backpressure: stall parks an accepted word in a one-entry skid and drops imem_req until released.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] pc_ID,
  output logic        valid_ID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;

  // Redirect address is always word aligned.
  logic [31:0] target;
  assign target = branch_target & ~32'h0000_0003;

  // Request decode comes straight from state/address flops, so it is glitch free.
  // DRAIN keeps presenting the abandoned address until memory answers it.
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign instr    = instr_q;
  assign pc_ID    = pc_id_q;
  assign valid_ID = valid_id_q;

  // Next-state, PC and IF/ID update; flush always takes priority over stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_id_d   = valid_id_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (flush) begin
          pc_d       = target;
          instr_d    = NOP;
          valid_id_d = 1'b0;
        end
      end

      FETCH: begin
        if (flush) begin
          // Whatever is in flight is wrong-path: squash IF/ID and redirect.
          pc_d       = target;
          instr_d    = NOP;
          valid_id_d = 1'b0;
          if (!imem_ready) begin
            // Request not yet answered: keep it on the bus until it completes.
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (!stall) begin
            instr_d    = imem_rdata;
            pc_id_d    = pc_q;
            valid_id_d = 1'b1;
          end else begin
            // Decode is blocked: park the word so it is not lost.
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (!stall) begin
          instr_d    = NOP;
          valid_id_d = 1'b0;
        end
      end

      HOLD: begin
        if (flush) begin
          // Parked word is wrong-path; it is simply never delivered.
          pc_d       = target;
          instr_d    = NOP;
          valid_id_d = 1'b0;
          state_d    = FETCH;
        end else if (!stall) begin
          instr_d    = skid_q;
          pc_id_d    = skid_pc_q;
          valid_id_d = 1'b1;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        if (flush) begin
          // A newer redirect supersedes the pending one; keep draining.
          pc_d       = target;
          instr_d    = NOP;
          valid_id_d = 1'b0;
        end else begin
          if (imem_ready) begin
            state_d = FETCH;
          end
          if (!stall) begin
            instr_d    = NOP;
            valid_id_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      skid_q       <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= NOP;
      pc_id_q      <= 32'h0;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

endmodule
